// File: rtl/fe_iq.sv
// fe_iq: fetch instruction queue between fetch buffer and decode (optional FE_IQ_BYPASS_EN)
package fe_iq_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } t_fb_fe_rsp;
endpackage

module fe_iq
  import fe_iq_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fb_iq_rq_nnn,
  input  t_fb_fe_rsp       fb_iq_pkt_nnn,
  output logic             iq_fb_gn_nnn,
  output logic             iq_de_valid_nnn,
  output t_fb_fe_rsp       iq_de_pkt_nnn,
  input  logic             de_iq_stall_nnn,
  input  logic             flush_nnn,
  output logic [PTR_W-1:0] iq_count_nnn,
  output logic             iq_full_nnn
);
  t_fb_fe_rsp       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, push, pop, byp;
  assign iq_count_nnn = wr_ptr - rd_ptr;
  assign empty        = wr_ptr == rd_ptr;
  assign iq_full_nnn  = (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]) & (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign iq_fb_gn_nnn = reset_n & fb_iq_rq_nnn & ~iq_full_nnn & ~flush_nnn;
`ifdef FE_IQ_BYPASS_EN
  assign byp = iq_fb_gn_nnn & empty & ~de_iq_stall_nnn;
`else
  assign byp = 1'b0;
`endif
  assign push            = iq_fb_gn_nnn & ~byp;
  assign pop             = ~empty & ~de_iq_stall_nnn & ~flush_nnn;
  assign iq_de_valid_nnn = ~empty | byp;
  // head packet toward decode; bypass forwards the incoming packet when the queue is empty
  always_comb begin
    iq_de_pkt_nnn       = ~empty ? mem[rd_ptr[PTR_W-2:0]] : byp ? fb_iq_pkt_nnn : '0;
    iq_de_pkt_nnn.valid = iq_de_valid_nnn;
  end
  // pointer update; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_nnn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
    end
  end
  // storage is never reset; only written on push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-2:0]] <= fb_iq_pkt_nnn;
  end
  // protocol and occupancy sanity checks
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (iq_count_nnn <= PTR_W'(DEPTH));
      assert (!fb_iq_rq_nnn || fb_iq_pkt_nnn.valid);
      assert (!(pop && empty));
    end
  end
endmodule

// File: tb/tb_fe_iq.sv
// tb_fe_iq: directed self-checking bench for fe_iq (honours FE_IQ_BYPASS_EN)
module tb_fe_iq;
  import fe_iq_pkg::*;
  logic       clk = 0, reset_n = 0, rq = 0, stall = 0, flush = 0;
  logic       gn, de_valid, full;
  logic [3:0] count;
  t_fb_fe_rsp pkt_in = '0, pkt_out;
  int         total = 0, errs = 0;
  fe_iq #(.DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .fb_iq_rq_nnn(rq), .fb_iq_pkt_nnn(pkt_in),
    .iq_fb_gn_nnn(gn), .iq_de_valid_nnn(de_valid), .iq_de_pkt_nnn(pkt_out),
    .de_iq_stall_nnn(stall), .flush_nnn(flush), .iq_count_nnn(count), .iq_full_nnn(full)
  );
  always #5 clk = ~clk;
  function automatic t_fb_fe_rsp mk(logic [31:0] pc);
    t_fb_fe_rsp p;
    p.instr = ~pc ^ 32'h0000_0013;
    p.pc    = pc;
    p.valid = 1'b1;
    return p;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] q[$];
    int          sent;
    bit          bp, egn, ebyp;
    bp = 0;
`ifdef FE_IQ_BYPASS_EN
    bp = 1;
`endif
    rq = 1; pkt_in = mk(32'h999);
    cyc; cyc;
    #1;
    chk("rst_gn", gn, 0);
    chk("rst_valid", de_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_pkt", pkt_out, 0);
    rq = 0; reset_n = 1;
    cyc;
    rq = 1; pkt_in = mk(32'h1000); stall = 0;
    #1;
    chk("single_gn", gn, 1);
`ifdef FE_IQ_BYPASS_EN
    chk("single_byp_valid", de_valid, 1);
    chk("single_byp_pc", pkt_out.pc, 32'h1000);
    cyc; rq = 0; #1;
    chk("single_byp_count", count, 0);
`else
    chk("single_valid0", de_valid, 0);
    cyc; rq = 0; #1;
    chk("single_valid1", de_valid, 1);
    chk("single_pc", pkt_out.pc, 32'h1000);
    chk("single_instr", pkt_out.instr, mk(32'h1000).instr);
    chk("single_count1", count, 1);
    cyc; #1;
    chk("single_count0", count, 0);
    chk("single_valid_end", de_valid, 0);
    chk("empty_pkt", pkt_out, 0);
`endif
    stall = 1;
    for (int i = 0; i < 8; i++) begin
      rq = 1; pkt_in = mk(32'(4 * i));
      #1;
      chk("fill_gn", gn, 1);
      cyc;
    end
    pkt_in = mk(32'h20);
    #1;
    chk("full_count", count, 8);
    chk("full_flag", full, 1);
    chk("full_gn", gn, 0);
    stall = 0;
    #1;
    chk("full_pop_gn", gn, 0);
    chk("drain_pc0", pkt_out.pc, 0);
    cyc; rq = 0;
    for (int i = 1; i < 8; i++) begin
      #1;
      chk("drain_valid", de_valid, 1);
      chk("drain_pc", pkt_out.pc, 64'(4 * i));
      chk("drain_instr", pkt_out.instr, mk(32'(4 * i)).instr);
      cyc;
    end
    #1;
    chk("drain_count", count, 0);
    sent = 0;
    for (int c = 0; c < 200 && (sent < 20 || q.size() != 0); c++) begin
      stall = c[0];
      rq = sent < 20;
      pkt_in = rq ? mk(32'h100 + 32'(4 * sent)) : '0;
      #1;
      egn  = rq && q.size() < 8;
      ebyp = bp && egn && q.size() == 0 && !stall;
      chk("wrap_gn", gn, egn);
      chk("wrap_valid", de_valid, q.size() != 0 || ebyp);
      chk("wrap_count", count, q.size());
      if (q.size() != 0) chk("wrap_pc", pkt_out.pc, q[0]);
      else if (ebyp) chk("wrap_byp_pc", pkt_out.pc, pkt_in.pc);
      if (q.size() != 0 && !stall) void'(q.pop_front());
      if (egn && !ebyp) q.push_back(pkt_in.pc);
      if (egn) sent++;
      cyc;
    end
    rq = 0;
    chk("wrap_sent", sent, 20);
    #1;
    chk("wrap_end_count", count, 0);
    stall = 1;
    for (int i = 0; i < 5; i++) begin
      rq = 1; pkt_in = mk(32'h500 + 32'(4 * i));
      cyc;
    end
    pkt_in = mk(32'h3000); flush = 1;
    #1;
    chk("flush_count5", count, 5);
    chk("flush_gn", gn, 0);
    cyc; flush = 0;
    #1;
    chk("flush_count0", count, 0);
    chk("flush_valid", de_valid, 0);
    chk("post_flush_gn", gn, 1);
    cyc; rq = 0;
    #1;
    chk("post_flush_count", count, 1);
    chk("post_flush_pc", pkt_out.pc, 32'h3000);
    stall = 0;
    cyc; #1;
    chk("post_flush_drain", count, 0);
    rq = 1; pkt_in = mk(32'h2000);
    #1;
    chk("byp_gn", gn, 1);
`ifdef FE_IQ_BYPASS_EN
    chk("byp_valid", de_valid, 1);
    chk("byp_pc", pkt_out.pc, 32'h2000);
    chk("byp_count", count, 0);
    cyc; rq = 0; #1;
    chk("byp_count_after", count, 0);
`else
    chk("nobyp_valid", de_valid, 0);
    cyc; rq = 0; #1;
    chk("nobyp_valid_next", de_valid, 1);
    chk("nobyp_pc_next", pkt_out.pc, 32'h2000);
    cyc;
`endif
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      rq = 1; pkt_in = mk(32'h700 + 32'(4 * i));
      cyc;
    end
    #1;
    chk("mid_count2", count, 2);
    reset_n = 0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_gn", gn, 0);
    chk("mid_rst_valid", de_valid, 0);
    cyc; reset_n = 1; rq = 0;
    cyc;
    $display("%0d/%0d checks passed", total - errs, total);
    $finish;
  end
endmodule
